// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the RV32I 5-stage pipeline control
// Purpose: forwarding-select and write-source encodings, ControlUnit opcode
//          constants, the per-stage shadow slot structs, and the "writes rd" helper.
// Ports:   none (package)
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF      = 2'b00,
    FWD_MEM_ALU = 2'b01,
    FWD_WB      = 2'b10,
    FWD_MEM_PC4 = 2'b11
  } fwd_sel_t;

  typedef enum logic [1:0] {
    WR_ALU = 2'b00,
    WR_MEM = 2'b01,
    WR_PC4 = 2'b10
  } wrsrc_t;

  // RV32I opcodes as decoded by ControlUnit
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             ruwr;
    wrsrc_t           wrsrc;
  } stage_info_t;

  // EX slot additionally remembers what the instruction reads
  typedef struct packed {
    stage_info_t      info;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             use_rs1;
    logic             use_rs2;
  } ex_info_t;

  // x0 is hardwired, so a write to it never matters for hazards
  function automatic logic writes_rd(input stage_info_t s);
    return s.valid & s.ruwr & (s.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - forwarding source select for one EX operand
// Purpose: compares one EX source register against the MEM and WB shadow slots.
// Ports:   ex_valid/ex_rs/ex_use - EX slot validity, source index, source-used flag
//          mem, wb               - MEM and WB shadow slots
//          sel                   - selected operand source
module fwd_select
  import pipe_pkg::*;
(
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rs,
  input  logic             ex_use,
  input  stage_info_t      mem,
  input  stage_info_t      wb,
  output fwd_sel_t         sel
);

  always_comb begin
    sel = FWD_RF;
    if (ex_valid) begin
      // MEM is younger than WB, so it wins. A load in MEM never reaches
      // here with a dependent in EX because the load-use stall intervenes.
      if (ex_use && writes_rd(mem) && (mem.rd == ex_rs)) begin
        sel = (mem.wrsrc == WR_PC4) ? FWD_MEM_PC4 : FWD_MEM_ALU;
      end else if (writes_rd(wb) && (wb.rd == ex_rs)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forward sequencing for the 5-stage RV32I core
// Purpose: shadows EX/MEM/WB destination info and drives pipeline-register
//          enables, flushes, operand forwarding selects and perf counters.
// Ports:   clk, rst_n (sync, active-low)
//          id_*        - decoded ID-stage control and register indices
//          ex_br_taken - EX branch/jump resolved taken
//          ext_stall   - data-memory wait, freezes everything
//          pc_en, ifid_en, flush_ifid, flush_idex - pipeline register control
//          fwd_a, fwd_b - EX operand sources
//          stall_count, flush_count - saturating perf counters
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int XLEN_REG = REG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [XLEN_REG-1:0] id_rs1,
  input  logic [XLEN_REG-1:0] id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [XLEN_REG-1:0] id_rd,
  input  logic                id_ruwr,
  input  logic [1:0]          id_wrsrc,
  input  logic                ex_br_taken,
  input  logic                ext_stall,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                flush_ifid,
  output logic                flush_idex,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    flush_count
);

  ex_info_t         ex_q;
  stage_info_t      mem_q;
  stage_info_t      wb_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  ex_info_t id_slot;
  logic     lu;
  logic     redir;
  logic     do_stall;
  logic     do_flush;
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;

  always_comb begin
    id_slot            = '0;
    id_slot.info.valid = id_valid;
    id_slot.info.rd    = id_rd;
    id_slot.info.ruwr  = id_ruwr;
    id_slot.info.wrsrc = wrsrc_t'(id_wrsrc);
    id_slot.rs1        = id_rs1;
    id_slot.rs2        = id_rs2;
    id_slot.use_rs1    = id_use_rs1;
    id_slot.use_rs2    = id_use_rs2;
  end

  assign lu = id_valid & writes_rd(ex_q.info) & (ex_q.info.wrsrc == WR_MEM) &
              ((id_use_rs1 & (id_rs1 == ex_q.info.rd)) |
               (id_use_rs2 & (id_rs2 == ex_q.info.rd)));
  assign redir = ex_br_taken & ex_q.info.valid;

  // A redirect squashes the ID instruction, so its load-use hazard is moot
  assign do_flush = ~ext_stall & redir;
  assign do_stall = ~ext_stall & ~redir & lu;

  fwd_select u_fwd_a (
    .ex_valid (ex_q.info.valid),
    .ex_rs    (ex_q.rs1),
    .ex_use   (ex_q.use_rs1),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (sel_a)
  );

  fwd_select u_fwd_b (
    .ex_valid (ex_q.info.valid),
    .ex_rs    (ex_q.rs2),
    .ex_use   (ex_q.use_rs2),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (sel_b)
  );

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    fwd_a      = sel_a;
    fwd_b      = sel_b;
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      fwd_a      = FWD_RF;
      fwd_b      = FWD_RF;
    end else if (ext_stall) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else if (redir) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      flush_idex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else if (!ext_stall) begin
      wb_q  <= mem_q;
      mem_q <= ex_q.info;
      ex_q  <= flush_idex ? '0 : id_slot;
      if (do_stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (do_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_ruwr;
  logic [1:0]    id_wrsrc;
  logic          ex_br_taken, ext_stall;
  logic          pc_en, ifid_en, flush_ifid, flush_idex;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_count, flush_count;

  pipeline_hazard_ctrl #(.CNT_W(CW), .XLEN_REG(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_ruwr     (id_ruwr),
    .id_wrsrc    (id_wrsrc),
    .ex_br_taken (ex_br_taken),
    .ext_stall   (ext_stall),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ruwr;
    logic [1:0] wrsrc;
  } ins_t;

  typedef struct {
    string      name;
    logic [3:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    int         sc;
    int         fc;
  } exp_t;

  // {pc_en, ifid_en, flush_ifid, flush_idex}
  localparam logic [3:0] N = 4'b1100;
  localparam logic [3:0] S = 4'b0001;
  localparam logic [3:0] R = 4'b1111;
  localparam logic [3:0] X = 4'b0000;
  localparam logic [3:0] Z = 4'b0011;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic ins_t nop();
    return '0;
  endfunction
  function automatic ins_t rr(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return '{v:1'b1, rs1:a, rs2:b, u1:1'b1, u2:1'b1, rd:rd, ruwr:1'b1, wrsrc:2'b00};
  endfunction
  function automatic ins_t ri(input logic [4:0] rd, input logic [4:0] a);
    return '{v:1'b1, rs1:a, rs2:5'd0, u1:1'b1, u2:1'b0, rd:rd, ruwr:1'b1, wrsrc:2'b00};
  endfunction
  function automatic ins_t ld(input logic [4:0] rd, input logic [4:0] a);
    return '{v:1'b1, rs1:a, rs2:5'd0, u1:1'b1, u2:1'b0, rd:rd, ruwr:1'b1, wrsrc:2'b01};
  endfunction
  function automatic ins_t jal(input logic [4:0] rd);
    return '{v:1'b1, rs1:5'd0, rs2:5'd0, u1:1'b0, u2:1'b0, rd:rd, ruwr:1'b1, wrsrc:2'b10};
  endfunction

  task automatic drive(input logic rst, input logic xs, input logic br, input ins_t i);
    rst_n       = rst;
    ext_stall   = xs;
    ex_br_taken = br;
    id_valid    = i.v;
    id_rs1      = i.rs1;
    id_rs2      = i.rs2;
    id_use_rs1  = i.u1;
    id_use_rs2  = i.u2;
    id_rd       = i.rd;
    id_ruwr     = i.ruwr;
    id_wrsrc    = i.wrsrc;
  endtask

  task automatic step(input string nm, input logic rst, input logic xs, input logic br,
                      input ins_t i, input logic [3:0] ctl, input logic [1:0] fa,
                      input logic [1:0] fb, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    drive(rst, xs, br, i);
    e.name = nm; e.ctl = ctl; e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0d expected=%0d", nm, fld, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp(e.name, "pc_en",       int'(pc_en),       int'(e.ctl[3]));
        cmp(e.name, "ifid_en",     int'(ifid_en),     int'(e.ctl[2]));
        cmp(e.name, "flush_ifid",  int'(flush_ifid),  int'(e.ctl[1]));
        cmp(e.name, "flush_idex",  int'(flush_idex),  int'(e.ctl[0]));
        cmp(e.name, "fwd_a",       int'(fwd_a),       int'(e.fa));
        cmp(e.name, "fwd_b",       int'(fwd_b),       int'(e.fb));
        cmp(e.name, "stall_count", int'(stall_count), e.sc);
        cmp(e.name, "flush_count", int'(flush_count), e.fc);
      end
    end
  end

  initial begin : stim
    int sat0, sat1;
    drive(1'b0, 1'b0, 1'b0, nop());
    repeat (2) @(posedge clk);
    step("reset",     0, 0, 0, nop(),             Z, 2'b00, 2'b00, 0, 0);
    // add x5,x1,x2 ; sub x6,x5,x3
    step("t1_add",    1, 0, 0, rr(5, 1, 2),       N, 2'b00, 2'b00, 0, 0);
    step("t1_sub",    1, 0, 0, rr(6, 5, 3),       N, 2'b00, 2'b00, 0, 0);
    step("t1_fwd",    1, 0, 0, nop(),             N, 2'b01, 2'b00, 0, 0);
    // jal x1 ; addi x2,x1,4 at distance 1, 2, 3
    step("t2a_jal",   1, 0, 0, jal(1),            N, 2'b00, 2'b00, 0, 0);
    step("t2a_addi",  1, 0, 0, ri(2, 1),          N, 2'b00, 2'b00, 0, 0);
    step("t2a_fwd",   1, 0, 0, nop(),             N, 2'b11, 2'b00, 0, 0);
    step("t2b_jal",   1, 0, 0, jal(1),            N, 2'b00, 2'b00, 0, 0);
    step("t2b_ind",   1, 0, 0, rr(10, 11, 12),    N, 2'b00, 2'b00, 0, 0);
    step("t2b_addi",  1, 0, 0, ri(2, 1),          N, 2'b00, 2'b00, 0, 0);
    step("t2b_fwd",   1, 0, 0, nop(),             N, 2'b10, 2'b00, 0, 0);
    step("t2c_jal",   1, 0, 0, jal(1),            N, 2'b00, 2'b00, 0, 0);
    step("t2c_ind1",  1, 0, 0, rr(10, 11, 12),    N, 2'b00, 2'b00, 0, 0);
    step("t2c_ind2",  1, 0, 0, rr(10, 11, 12),    N, 2'b00, 2'b00, 0, 0);
    step("t2c_addi",  1, 0, 0, ri(2, 1),          N, 2'b00, 2'b00, 0, 0);
    step("t2c_fwd",   1, 0, 0, nop(),             N, 2'b00, 2'b00, 0, 0);
    // lw x7,0(x4) ; add x8,x7,x7
    step("t3_lw",     1, 0, 0, ld(7, 4),          N, 2'b00, 2'b00, 0, 0);
    step("t3_stall",  1, 0, 0, rr(8, 7, 7),       S, 2'b00, 2'b00, 0, 0);
    step("t3_bubble", 1, 0, 0, rr(8, 7, 7),       N, 2'b00, 2'b00, 1, 0);
    step("t3_fwd",    1, 0, 0, nop(),             N, 2'b10, 2'b10, 1, 0);
    // x0 never forwards or stalls
    step("t4_addi0",  1, 0, 0, ri(0, 0),          N, 2'b00, 2'b00, 1, 0);
    step("t4_add9",   1, 0, 0, rr(9, 0, 0),       N, 2'b00, 2'b00, 1, 0);
    step("t4_fwd",    1, 0, 0, nop(),             N, 2'b00, 2'b00, 1, 0);
    step("t4_lw0",    1, 0, 0, ld(0, 4),          N, 2'b00, 2'b00, 1, 0);
    step("t4_nostall",1, 0, 0, rr(9, 0, 0),       N, 2'b00, 2'b00, 1, 0);
    step("t4_after",  1, 0, 0, nop(),             N, 2'b00, 2'b00, 1, 0);
    // redirect beats load-use
    step("t5_lw",     1, 0, 0, ld(7, 4),          N, 2'b00, 2'b00, 1, 0);
    step("t5_redir",  1, 0, 1, rr(8, 7, 7),       R, 2'b00, 2'b00, 1, 0);
    step("t5_bubble", 1, 0, 0, rr(8, 7, 7),       N, 2'b00, 2'b00, 1, 1);
    step("t5_after",  1, 0, 0, nop(),             N, 2'b10, 2'b10, 1, 1);
    // ext_stall over a load-use stall, then reset
    step("t6_lw",     1, 0, 0, ld(7, 4),          N, 2'b00, 2'b00, 1, 1);
    step("t6_xs1",    1, 1, 0, rr(8, 7, 7),       X, 2'b00, 2'b00, 1, 1);
    step("t6_xs2",    1, 1, 0, rr(8, 7, 7),       X, 2'b00, 2'b00, 1, 1);
    step("t6_xs3",    1, 1, 0, rr(8, 7, 7),       X, 2'b00, 2'b00, 1, 1);
    step("t6_stall",  1, 0, 0, rr(8, 7, 7),       S, 2'b00, 2'b00, 1, 1);
    step("t6_bubble", 1, 0, 0, rr(8, 7, 7),       N, 2'b00, 2'b00, 2, 1);
    step("t6_rst",    0, 0, 0, nop(),             Z, 2'b00, 2'b00, 2, 1);
    step("t6_rel",    1, 0, 0, rr(8, 7, 7),       N, 2'b00, 2'b00, 0, 0);
    step("t6_rel2",   1, 0, 0, nop(),             N, 2'b00, 2'b00, 0, 0);
    // stall counter saturates at all-ones (3 for a 2-bit counter)
    for (int k = 0; k < 4; k++) begin
      sat0 = (k > 3) ? 3 : k;
      sat1 = (k + 1 > 3) ? 3 : k + 1;
      step("sat_lw",     1, 0, 0, ld(7, 4),    N, 2'b00, 2'b00, sat0, 0);
      step("sat_stall",  1, 0, 0, rr(8, 7, 7), S, 2'b00, 2'b00, sat0, 0);
      step("sat_bubble", 1, 0, 0, rr(8, 7, 7), N, 2'b00, 2'b00, sat1, 0);
      step("sat_fwd",    1, 0, 0, nop(),       N, 2'b10, 2'b10, sat1, 0);
    end
    for (int w = 0; w < 5 && q.size() != 0; w++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
